video_pattern_gen: RTL and testbench

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

---
 rtl/video_pattern_gen.sv | 109 ++++++++++
 tb/tb_video_pattern_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: video timing generator with colour bar / ramp / checkerboard / solid test patterns.
// Define PATTERN_NOISE_EN to overlay 1/32-rate impulse noise from a 16-bit Fibonacci LFSR.
module video_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] pattern,
    output logic [7:0] tx_red,
    output logic [7:0] tx_green,
    output logic [7:0] tx_blue,
    output logic       tx_dv,
    output logic       tx_hs,
    output logic       tx_vs,
    output logic       frame_start
);
    localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] H_SS     = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SE     = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] H_MAX    = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
    localparam logic [15:0] V_SS     = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] V_SE     = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] V_MAX    = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] BAR_LAST = 16'(H_ACTIVE / 8 - 1);

    logic [15:0] r_h_cnt, r_v_cnt, r_bar_cnt;
    logic [3:0]  r_bar_idx;
    logic [1:0]  r_pat;
    logic        w_h_wrap, w_first, w_act, w_hs, w_vs;
    logic [1:0]  w_pat;
    logic [23:0] w_bar, w_pix, w_rgb;

    assign w_h_wrap = (r_h_cnt == H_MAX);
    assign w_first  = (r_h_cnt == 16'd0) && (r_v_cnt == 16'd0);
    assign w_act    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs     = (r_h_cnt >= H_SS) && (r_h_cnt < H_SE);
    assign w_vs     = (r_v_cnt >= V_SS) && (r_v_cnt < V_SE);
    // New pattern is taken at the first pixel of a frame and applies to that pixel already
    assign w_pat    = w_first ? pattern : r_pat;
    // Bar index 8 marks the remainder pixels after the eighth bar, which stay black
    assign w_bar    = r_bar_idx[3] ? 24'h0 : {{8{~r_bar_idx[1]}}, {8{~r_bar_idx[2]}}, {8{~r_bar_idx[0]}}};
    assign w_pix    = (w_pat == 2'd0) ? w_bar :
                      (w_pat == 2'd1) ? {3{r_h_cnt[7:0]}} :
                      (w_pat == 2'd2) ? {24{r_h_cnt[3] ^ r_v_cnt[3]}} : {3{8'h80}};

    // Raster counters, bar position counter and frame-latched pattern
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
            r_pat     <= '0;
        end else if (!en) begin
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else begin
            r_h_cnt   <= w_h_wrap ? 16'd0 : r_h_cnt + 16'd1;
            if (w_h_wrap) r_v_cnt <= (r_v_cnt == V_MAX) ? 16'd0 : r_v_cnt + 16'd1;
            r_bar_cnt <= (w_h_wrap || r_bar_cnt == BAR_LAST) ? 16'd0 : r_bar_cnt + 16'd1;
            r_bar_idx <= w_h_wrap ? 4'd0 :
                         (r_bar_cnt == BAR_LAST && r_bar_idx != 4'd8) ? r_bar_idx + 4'd1 : r_bar_idx;
            r_pat     <= w_pat;
        end
    end

`ifdef PATTERN_NOISE_EN
    logic [15:0] r_lfsr;
    // LFSR advances once per active pixel; its low bits pick impulse pixels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lfsr <= 16'hACE1;
        else if (en && w_act) r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_rgb = (r_lfsr[4:0] == 5'd0) ? {24{r_lfsr[5]}} : w_pix;
`else
    assign w_rgb = w_pix;
`endif

    // Output register: one cycle behind the counters, idle while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_dv       <= 1'b0;
            tx_hs       <= ~SYNC_POL;
            tx_vs       <= ~SYNC_POL;
            tx_red      <= '0;
            tx_green    <= '0;
            tx_blue     <= '0;
            frame_start <= 1'b0;
        end else begin
            tx_dv       <= en & w_act;
            tx_hs       <= (en & w_hs) ? SYNC_POL : ~SYNC_POL;
            tx_vs       <= (en & w_vs) ? SYNC_POL : ~SYNC_POL;
            {tx_red, tx_green, tx_blue} <= (en & w_act) ? w_rgb : 24'h0;
            frame_start <= en & w_first;
        end
    end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: directed checks of timing, patterns, enable and reset of video_pattern_gen.
module tb_video_pattern_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] pattern = 2'd0;
    logic [7:0] tx_red, tx_green, tx_blue;
    logic       tx_dv, tx_hs, tx_vs, frame_start;
    logic [23:0] rgb;
    int n_chk = 0;
    int n_err = 0;
    int dv_n = 0;
    int hs_n = 0;
    int vs_n = 0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    assign rgb = {tx_red, tx_green, tx_blue};

    video_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pattern(pattern),
        .tx_red(tx_red), .tx_green(tx_green), .tx_blue(tx_blue),
        .tx_dv(tx_dv), .tx_hs(tx_hs), .tx_vs(tx_vs), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_dv", tx_dv, 0);
        check("rst_hs", tx_hs, 0);
        check("rst_vs", tx_vs, 0);
        check("rst_rgb", rgb, 0);
        check("rst_fs", frame_start, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_dv", tx_dv, 0);
        en = 1'b1;
        @(negedge clk);
        check("f1_fs", frame_start, 1);
        // frame 1: colour bars, timing totals, mid-frame pattern change deferred
        for (int i = 0; i < 154; i++) begin
            int h, v;
            h = i % 22;
            v = i / 22;
            dv_n += int'(tx_dv);
            hs_n += int'(tx_hs);
            vs_n += int'(tx_vs);
            if (v == 0 && h < 16) check("bar", rgb, bars[h/2]);
            if (v == 0 && h >= 16) check("hs_line0", tx_hs, (h == 18 || h == 19));
            if (i == 24) check("bar_after_switch", rgb, 24'hFFFF00);
            if (i == 109) check("vs_before", tx_vs, 0);
            if (i == 110) check("vs_on", tx_vs, 1);
            if (i == 1) check("fs_pulse_end", frame_start, 0);
            if (i == 10) pattern = 2'd1;
            @(negedge clk);
        end
        check("dv_count", dv_n, 64);
        check("hs_count", hs_n, 14);
        check("vs_count", vs_n, 22);
        // frame 2: ramp, switch to checkerboard mid-frame
        check("f2_fs", frame_start, 1);
        check("f2_ramp0", rgb, 24'h000000);
        for (int i = 0; i < 154; i++) begin
            if (i == 5) check("ramp5", rgb, 24'h050505);
            if (i == 53) check("ramp_after_switch", rgb, 24'h090909);
            if (i == 30) pattern = 2'd2;
            @(negedge clk);
        end
        // frame 3: checkerboard, then enable drop at line 2 pixel 3
        check("f3_fs", frame_start, 1);
        check("chk_h0", rgb, 24'h000000);
        for (int i = 0; i < 47; i++) begin
            if (i == 8) check("chk_h8", rgb, 24'hFFFFFF);
            if (i == 26) check("chk_l1_h4", rgb, 24'h000000);
            if (i == 34) check("chk_l1_h12", rgb, 24'hFFFFFF);
            @(negedge clk);
        end
        check("pre_drop_dv", tx_dv, 1);
        en = 1'b0;
        @(negedge clk);
        check("drop_dv", tx_dv, 0);
        check("drop_hs", tx_hs, 0);
        check("drop_vs", tx_vs, 0);
        check("drop_rgb", rgb, 0);
        check("drop_fs", frame_start, 0);
        repeat (3) @(negedge clk);
        check("hold_dv", tx_dv, 0);
        pattern = 2'd3;
        en = 1'b1;
        @(negedge clk);
        check("reen_fs", frame_start, 1);
        check("reen_solid", rgb, 24'h808080);
        check("reen_dv", tx_dv, 1);
        // asynchronous reset in the middle of the horizontal sync
        repeat (18) @(negedge clk);
        check("pre_rst_hs", tx_hs, 1);
        #2 rst = 1'b1;
        #1;
        check("async_hs", tx_hs, 0);
        check("async_dv", tx_dv, 0);
        check("async_rgb", rgb, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_fs", frame_start, 1);
`ifdef PATTERN_NOISE_EN
        begin
            logic [15:0] ml;
            logic [23:0] exp;
            int bad, hits, pix;
            ml = 16'hACE1;
            bad = 0;
            hits = 0;
            pix = 0;
            for (int i = 0; i < 16 * 154; i++) begin
                if (tx_dv) begin
                    exp = (ml[4:0] == 5'd0) ? {24{ml[5]}} : 24'h808080;
                    if (rgb !== exp) bad++;
                    if (rgb != 24'h808080) hits++;
                    pix++;
                    ml = {ml[14:0], ml[15] ^ ml[13] ^ ml[12] ^ ml[10]};
                end
                @(negedge clk);
            end
            check("noise_pixels", pix, 1024);
            check("noise_model", bad, 0);
            check("noise_rate", (hits >= 20 && hits <= 45), 1);
        end
`else
        check("post_rst_solid", rgb, 24'h808080);
`endif
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
